// File: rtl/fun_pkg.sv
// Shared encodings for the root-function generator: mode select, FSM states
// and the cube-root iteration count.
package fun_pkg;

    // Function select, captured together with start_i.
    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_SQRT = 2'b01,
        MODE_CBRT = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    // Top-level controller states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSqrt = 2'b01,
        StCbrt = 2'b10,
        StDone = 2'b11
    } state_e;

    // One cube-root iteration per 3-bit group of the operand: ceil(width/3).
    function automatic int unsigned nc_calc(input int unsigned width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial
// product per cycle. busy_o rises on the start edge and falls after exactly
// WIDTH further edges, at which point p_o holds the full product.
module mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Load operands on start, then add/shift one multiplier bit per cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i && !busy_q) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign p_o    = acc_q;

endmodule

// File: rtl/fun_gen.sv
// Root-function generator: y = floor(sqrt(A)) and/or floor(cbrt(B)).
// Square root is restoring digit-by-digit (one bit per cycle); cube root is
// the bitwise method, using mul_seq for the 3*y*(y+1) term of each step.
module fun_gen
    import fun_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_bo
);

    localparam int unsigned NC = nc_calc(WIDTH);
    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e state_q, state_d;
    mode_e  mode_q;

    // Square-root datapath
    logic [WIDTH-1:0] sa_q;
    logic [HW-1:0]    rem_q;
    logic [HW-1:0]    root_q;
    logic [CW-1:0]    sq_cnt_q;

    // Cube-root datapath
    logic [WIDTH-1:0] cx_q;
    logic [WIDTH-1:0] cy_q;
    logic [CW-1:0]    itc_q;
    logic             cb_wait_q;

    logic [WIDTH-1:0] y_q;
    logic             done_q;

    // Controller strobes
    logic load, sq_step, cb_setup, cb_update, fin;

    // Multiplier interface
    logic               mul_start;
    logic               mul_busy;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_p;

    // Datapath helpers
    logic [HW+1:0]    sq_rem_sh;
    logic [HW+1:0]    sq_trial;
    logic             sq_ge;
    logic [WIDTH-1:0] cy_dbl;
    logic [CW+1:0]    cb_shamt;
    logic [WIDTH-1:0] cb_xs;
    logic [2*WIDTH:0] cb_trial;
    logic             cb_ge;

    mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .busy_o  (mul_busy),
        .p_o     (mul_p)
    );

    // Root-step arithmetic shared by the FSM-driven register updates.
    always_comb begin
        sq_rem_sh = {rem_q, sa_q[WIDTH-1 -: 2]};
        sq_trial  = {root_q, 2'b01};
        sq_ge     = (sq_rem_sh >= sq_trial);
        // Setup doubles y; the multiplier then sees 3*y and y+1 of the new y.
        cy_dbl    = cy_q << 1;
        mul_a     = cy_dbl + (cy_dbl << 1);
        mul_b     = cy_dbl + WIDTH'(1);
        // Group shift 3*itc; compare (x >> s) >= t instead of x >= (t << s) to avoid overflow.
        cb_shamt  = {2'b00, itc_q} + {1'b0, itc_q, 1'b0};
        cb_xs     = cx_q >> cb_shamt;
        cb_trial  = {1'b0, mul_p} + {{(2*WIDTH){1'b0}}, 1'b1};
        cb_ge     = ({{(WIDTH+1){1'b0}}, cb_xs} >= cb_trial);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        sq_step   = 1'b0;
        cb_setup  = 1'b0;
        cb_update = 1'b0;
        fin       = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    load = 1'b1;
                    case (mode_e'(mode_i))
                        MODE_BOTH, MODE_SQRT: state_d = StSqrt;
                        MODE_CBRT:            state_d = StCbrt;
                        default:              state_d = StDone;
                    endcase
                end
            end
            StSqrt: begin
                sq_step = 1'b1;
                if (sq_cnt_q == CW'(1)) begin
                    state_d = (mode_q == MODE_BOTH) ? StCbrt : StDone;
                end
            end
            StCbrt: begin
                if (!cb_wait_q) begin
                    cb_setup  = 1'b1;
                    mul_start = 1'b1;
                end else if (!mul_busy) begin
                    cb_update = 1'b1;
                    if (itc_q == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                fin     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand latch, root iterations and result register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_q    <= MODE_BOTH;
            sa_q      <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            sq_cnt_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            itc_q     <= '0;
            cb_wait_q <= 1'b0;
            y_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                mode_q    <= mode_e'(mode_i);
                sa_q      <= a_bi;
                rem_q     <= '0;
                root_q    <= '0;
                sq_cnt_q  <= CW'(HW);
                cx_q      <= b_bi;
                cy_q      <= '0;
                itc_q     <= CW'(NC - 1);
                cb_wait_q <= 1'b0;
            end
            if (sq_step) begin
                // Final-step remainder may lose its top bit; it is never used again.
                rem_q    <= HW'(sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh);
                root_q   <= {root_q[HW-2:0], sq_ge};
                sa_q     <= sa_q << 2;
                sq_cnt_q <= sq_cnt_q - CW'(1);
            end
            if (cb_setup) begin
                cy_q      <= cy_dbl;
                cb_wait_q <= 1'b1;
            end
            if (cb_update) begin
                if (cb_ge) begin
                    cx_q <= cx_q - (cb_trial[WIDTH-1:0] << cb_shamt);
                    cy_q <= cy_q + WIDTH'(1);
                end
                cb_wait_q <= 1'b0;
                if (itc_q != '0) begin
                    itc_q <= itc_q - CW'(1);
                end
            end
            if (fin) begin
                case (mode_q)
                    MODE_BOTH: y_q <= {{(WIDTH-HW){1'b0}}, root_q} + cy_q;
                    MODE_SQRT: y_q <= {{(WIDTH-HW){1'b0}}, root_q};
                    MODE_CBRT: y_q <= cy_q;
                    default:   y_q <= '0;
                endcase
            end
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign y_bo   = y_q;

endmodule

// File: tb/tb_fun_gen.sv
// Bench for fun_gen: table vectors, sweeps and random operands against an
// arithmetic root model, plus hand sequences for ignored start, mid-run
// reset and 16-bit back-to-back operation.
module tb_fun_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8;
    logic [1:0] mode8;
    logic [7:0] a8, b8, y8;
    logic        start16, busy16, done16;
    logic [1:0]  mode16;
    logic [15:0] a16, b16, y16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] mode;
        int         a;
        int         b;
        int         y;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    fun_gen #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start8),
        .mode_i  (mode8),
        .a_bi    (a8),
        .b_bi    (b8),
        .busy_o  (busy8),
        .done_o  (done8),
        .y_bo    (y8)
    );

    fun_gen #(.WIDTH(16)) u_dut16 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start16),
        .mode_i  (mode16),
        .a_bi    (a16),
        .b_bi    (b16),
        .busy_o  (busy16),
        .done_o  (done16),
        .y_bo    (y16)
    );

    function automatic int isqrt_ref(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int icbrt_ref(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int model(input int mode, input int a, input int b);
        case (mode)
            0:       return isqrt_ref(a) + icbrt_ref(b);
            1:       return isqrt_ref(a);
            2:       return icbrt_ref(b);
            default: return 0;
        endcase
    endfunction

    function automatic int lat_ref(input int mode, input int w);
        int nc = (w + 2) / 3;
        case (mode)
            0:       return w / 2 + nc * (w + 2) + 1;
            1:       return w / 2 + 1;
            2:       return nc * (w + 2) + 1;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Issue one 8-bit operation; operands are scrambled after the start edge.
    task automatic run8(input int mode, input int a, input int b, output int y,
                        output int lat, output int busy_cyc, output int held);
        logic [7:0] y_prev;
        @(negedge clk);
        start8 = 1'b1;
        mode8  = mode[1:0];
        a8     = a[7:0];
        b8     = b[7:0];
        y_prev = y8;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        mode8  = 2'($urandom);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        lat = 0;
        busy_cyc = 0;
        held = 1;
        while (!done8 && lat < 200) begin
            if (busy8) busy_cyc++;
            if (y8 !== y_prev) held = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        y = int'(y8);
    endtask

    task automatic run16(input int mode, input int a, input int b, output int y,
                         output int lat, output int busy_cyc);
        @(negedge clk);
        start16 = 1'b1;
        mode16  = mode[1:0];
        a16     = a[15:0];
        b16     = b[15:0];
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16     = 16'($urandom);
        b16     = 16'($urandom);
        lat = 0;
        busy_cyc = 0;
        while (!done16 && lat < 400) begin
            if (busy16) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        y = int'(y16);
    endtask

    task automatic do8(input string tag, input int mode, input int a, input int b,
                       input int exp_y);
        int y, lat, bc, held;
        run8(mode, a, b, y, lat, bc, held);
        check({tag, " y"}, y, exp_y);
        check({tag, " latency"}, lat, lat_ref(mode, 8));
        check({tag, " busy cycles"}, bc, lat_ref(mode, 8));
        check({tag, " y held while busy"}, held, 1);
    endtask

    initial begin
        int y, lat, bc, dcount;
        int bset[7];

        vecs[0] = '{2'd0, 16,  27,  7,  35};
        vecs[1] = '{2'd0, 255, 255, 21, 35};
        vecs[2] = '{2'd1, 200, 3,   14, 5};
        vecs[3] = '{2'd2, 9,   64,  4,  31};
        vecs[4] = '{2'd3, 200, 200, 0,  1};
        vecs[5] = '{2'd0, 0,   0,   0,  35};
        vecs[6] = '{2'd2, 0,   255, 6,  31};
        vecs[7] = '{2'd1, 255, 0,   15, 5};
        vecs[8] = '{2'd2, 1,   1,   1,  31};
        vecs[9] = '{2'd0, 1,   8,   3,  35};
        bset = '{0, 1, 8, 27, 64, 125, 255};

        rst = 1'b0;
        start8 = 1'b0; mode8 = 2'd0; a8 = '0; b8 = '0;
        start16 = 1'b0; mode16 = 2'd0; a16 = '0; b16 = '0;
        #1;
        check("reset busy8", int'(busy8), 0);
        check("reset done8", int'(done8), 0);
        check("reset y8", int'(y8), 0);
        check("reset busy16", int'(busy16), 0);
        check("reset y16", int'(y16), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors with fixed expected values.
        for (int i = 0; i < 10; i++) begin
            int held;
            run8(int'(vecs[i].mode), vecs[i].a, vecs[i].b, y, lat, bc, held);
            check($sformatf("vec%0d y", i), y, vecs[i].y);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy cycles", i), bc, vecs[i].lat);
            check($sformatf("vec%0d y held", i), held, 1);
        end

        // Sweeps against the arithmetic model.
        for (int a = 0; a < 256; a++) do8($sformatf("sqrt a=%0d", a), 1, a, 0, model(1, a, 0));
        for (int j = 0; j < 7; j++) do8($sformatf("cbrt b=%0d", bset[j]), 2, 0, bset[j],
                                        model(2, 0, bset[j]));
        for (int a = 0; a < 256; a += 15) begin
            for (int j = 0; j < 7; j++) begin
                do8($sformatf("both a=%0d b=%0d", a, bset[j]), 0, a, bset[j],
                    model(0, a, bset[j]));
            end
        end
        for (int j = 0; j < 7; j++) do8($sformatf("none b=%0d", bset[j]), 3, 255, bset[j], 0);

        // Random operands.
        for (int k = 0; k < 40; k++) begin
            int m = int'($urandom_range(0, 3));
            int a = int'($urandom_range(0, 255));
            int b = int'($urandom_range(0, 255));
            do8($sformatf("rand m=%0d a=%0d b=%0d", m, a, b), m, a, b, model(m, a, b));
        end

        // Second start at cycle 10 of a running computation is ignored.
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'd16; b8 = 8'd27;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 200) begin
            if (lat == 9) begin
                @(negedge clk);
                start8 = 1'b1; mode8 = 2'd1; a8 = 8'd1; b8 = 8'd1;
                @(posedge clk);
                #1;
                start8 = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            lat++;
        end
        check("ignored start y", int'(y8), 7);
        check("ignored start latency", lat, 35);
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done8) dcount++;
        end
        check("ignored start not queued", dcount, 0);

        // Reset at cycle 12 of a mode-00 run aborts it immediately.
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'd100; b8 = 8'd100;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid reset busy", int'(busy8), 0);
        check("mid reset done", int'(done8), 0);
        check("mid reset y", int'(y8), 0);
        dcount = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done8) dcount++;
        end
        check("mid reset no done", dcount, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        do8("after reset", 0, 16, 27, 7);

        // 16-bit all-ones, then an immediate back-to-back start.
        run16(0, 65535, 65535, y, lat, bc);
        check("w16 ones y", y, 295);
        check("w16 ones latency", lat, 117);
        check("w16 ones busy", bc, 117);
        run16(0, 100, 1000, y, lat, bc);
        check("w16 b2b y", y, model(0, 100, 1000));
        check("w16 b2b latency", lat, lat_ref(0, 16));
        run16(2, 0, 65535, y, lat, bc);
        check("w16 cbrt y", y, model(2, 0, 65535));
        check("w16 cbrt latency", lat, lat_ref(2, 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fun_gen.md
FUN_GEN -- requirements
Module: fun_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width; legal values are even integers 4..32.
REQ-002 The block SHALL have derived constant NC = ceil(WIDTH/3), the number of cube-root iterations.
REQ-003 The block SHALL have port clk_i  in  1  sole clock, rising-edge.
REQ-004 The block SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start_i  in  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port mode_i  in  2  function select, captured with start_i.
REQ-007 The block SHALL have port a_bi  in  WIDTH  unsigned operand A.
REQ-008 The block SHALL have port b_bi  in  WIDTH  unsigned operand B.
REQ-009 The block SHALL have port busy_o  out  1  high while a computation is in progress.
REQ-010 The block SHALL have port done_o  out  1  one-cycle pulse when y_bo is updated.
REQ-011 The block SHALL have port y_bo  out  WIDTH  result, held between completions.

Function
REQ-012 The block SHALL decode mode_i as follows:
- 00: y = floor(sqrt(A)) + floor(cbrt(B)).
- 01: y = floor(sqrt(A)).
- 10: y = floor(cbrt(B)).
- 11: y = 0 (reserved).
REQ-013 The block SHALL compute all results without overflow of WIDTH bits, since sqrt < 2^(WIDTH/2) and cbrt < 2^NC.
REQ-014 The FSM SHALL have states IDLE, SQRT, CBRT, DONE.
REQ-015 IDLE SHALL move to SQRT on start_i=1 for mode 00/01, to CBRT for mode 10, and to DONE for mode 11.
REQ-016 On leaving IDLE, a_bi, b_bi and mode_i SHALL be latched; later input changes SHALL have no effect.
REQ-017 SQRT SHALL use digit-by-digit restoring square root, one result bit per cycle, and last exactly WIDTH/2 cycles.
REQ-018 SQRT SHALL then go to CBRT for mode 00 and to DONE for mode 01.
REQ-019 CBRT SHALL use the bitwise cube-root method for NC iterations, MSB group first.
REQ-020 Each CBRT iteration SHALL take exactly WIDTH+2 cycles: 1 setup, WIDTH multiply cycles on the sequential multiplier, 1 compare/subtract/update.
REQ-021 DONE SHALL last 1 cycle: load y_bo with the sum/selection, pulse done_o=1, then return to IDLE.
REQ-022 Latency from the start_i sampling edge to the edge at which done_o=1 SHALL be exactly:
- mode 00: WIDTH/2 + NC*(WIDTH+2) + 1.
- mode 01: WIDTH/2 + 1.
- mode 10: NC*(WIDTH+2) + 1.
- mode 11: 1.
REQ-023 For WIDTH=8 the latencies SHALL be 35 / 5 / 31 / 1 cycles.
REQ-024 busy_o SHALL be 1 in SQRT, CBRT and DONE, and 0 only in IDLE.
REQ-025 The cycle after done_o the block SHALL be in IDLE and SHALL accept a new start_i (back-to-back operation).
REQ-026 start_i while busy_o=1 SHALL be ignored, neither queued nor restarting the computation.
REQ-027 y_bo SHALL change only in DONE and SHALL hold its value otherwise, including while busy.
REQ-028 Operand value 0 SHALL give a root of 0; all-ones operands SHALL give the exact floor roots.

Reset
REQ-029 When rst_i=0, all state SHALL clear immediately and asynchronously: FSM=IDLE, busy_o=0, done_o=0, y_bo=0, and internal registers 0.
REQ-030 Reset asserted mid-computation SHALL abort the computation with no done_o pulse.
REQ-031 After rst_i rises, the first start_i SHALL be accepted on the next rising edge.

Structure
REQ-032 Package fun_pkg SHALL hold the mode encodings (MODE_BOTH, MODE_SQRT, MODE_CBRT, MODE_NONE), the FSM state encoding, and the NC computation function.
REQ-033 Sub-module mul_seq, a parametrised WIDTH x WIDTH shift-add sequential multiplier with start/busy handshake and WIDTH-cycle latency, SHALL compute 3*y*(y+1) in CBRT.
REQ-034 mul_seq SHALL be the only multiplier; SQRT SHALL use shifts and subtracts only.

Verification
REQ-035 WIDTH=8, mode 00, A=16, B=27 -> y_bo=7, done_o 35 cycles after start, busy_o high for exactly those cycles.
REQ-036 WIDTH=8, sweep A=0..255 and B in {0,1,8,27,64,125,255} for all modes -> y_bo matches a reference model, e.g. A=255, B=255, mode 00 -> 21; A=200, mode 01 -> 14; B=64, mode 10 -> 4.
REQ-037 WIDTH=8, start_i pulsed again at cycle 10 with A=1 -> ignored; result stays that of the first operands.
REQ-038 WIDTH=8, rst_i=0 at cycle 12 of a mode 00 run -> busy_o, y_bo and done_o go 0 immediately, no done_o pulse; the next run is correct.
REQ-039 WIDTH=16, mode 00, A=65535, B=65535 -> y_bo=295 after 16/2+6*18+1=117 cycles; back-to-back start on the following cycle accepted.
